// File: rtl/palette_pkg.sv
// Shared sizes, colour format and fade arithmetic for the VDP palette write controller.
package palette_pkg;

   localparam int PAL_ENTRIES = 32;
   localparam int PAL_AW      = 5;
   localparam int COMP_W      = 2;

   // Packed so that the bit layout matches the BBGGRR colour byte.
   typedef struct packed {
      logic [COMP_W-1:0] b;
      logic [COMP_W-1:0] g;
      logic [COMP_W-1:0] r;
   } colour_t;

   typedef enum logic {
      IDLE,
      SWEEP
   } sweep_state_t;

   // Each component is attenuated independently and saturates at zero.
   function automatic colour_t fade_scale(input colour_t c, input logic [COMP_W-1:0] level);
      colour_t s;
      s.r = (c.r > level) ? c.r - level : '0;
      s.g = (c.g > level) ? c.g - level : '0;
      s.b = (c.b > level) ? c.b - level : '0;
      return s;
   endfunction

endpackage

// File: rtl/palette_shadow.sv
// 32x6 shadow register file: one synchronous write port, one asynchronous read port,
// synchronous clear on reset.
module palette_shadow
   import palette_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [PAL_AW-1:0] waddr,
   input  colour_t           wdata,
   input  logic [PAL_AW-1:0] raddr,
   output colour_t           rdata
);

   colour_t mem [PAL_ENTRIES];

   // NOTE: every entry is cleared on reset, so this stays a flop array rather than a RAM;
   // a fade issued straight after reset must sweep black, not stale contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PAL_ENTRIES; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/palette_ctrl.sv
// Palette RAM write-port arbiter: CPU > host > fade sweep, with registered write outputs.
// The shadow copy, fade level and sweep engine are built only when PALETTE_FADE_EN is defined.
module palette_ctrl
   import palette_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [PAL_AW-1:0] cpu_addr,
   input  logic [7:0]        cpu_wrdata,
   input  logic              cpu_wren,
   input  logic [PAL_AW-1:0] host_addr,
   input  logic [7:0]        host_wrdata,
   input  logic              host_valid,
   output logic              host_ready,
   input  logic [1:0]        fade_level,
   input  logic              fade_start,
   output logic              fade_busy,
   output logic [PAL_AW-1:0] pal_addr,
   output logic [7:0]        pal_wrdata,
   output logic              pal_wren
);

   logic              host_take;
   logic              req_take;
   logic [PAL_AW-1:0] req_addr;
   colour_t           req_colour;
   logic              wren_d;
   logic [PAL_AW-1:0] addr_d;
   colour_t           colour_d;
   logic              unused_hi;

   // The CPU strobe can never be stalled, so the host only gets the port when the CPU is quiet.
   assign host_ready = ~cpu_wren;
   assign host_take  = host_valid & ~cpu_wren;
   assign req_take   = cpu_wren | host_take;
   assign req_addr   = cpu_wren ? cpu_addr : host_addr;
   assign req_colour = cpu_wren ? colour_t'(cpu_wrdata[5:0]) : colour_t'(host_wrdata[5:0]);
   assign unused_hi  = ^{cpu_wrdata[7:6], host_wrdata[7:6]};

`ifdef PALETTE_FADE_EN
   sweep_state_t      state, state_d;
   logic [1:0]        level, level_d, req_level;
   logic [PAL_AW-1:0] idx, idx_d;
   colour_t           shadow_rd;
   logic              sweep_go;

   palette_shadow u_shadow (
      .clk   (clk),
      .reset (reset),
      .we    (req_take),
      .waddr (req_addr),
      .wdata (req_colour),
      .raddr (idx),
      .rdata (shadow_rd)
   );

   // A request arriving with fade_start is scaled with the level being latched.
   assign req_level = fade_start ? fade_level : level;
   assign sweep_go  = (state == SWEEP) && !req_take && !fade_start;
   assign fade_busy = (state == SWEEP);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state;
      level_d  = level;
      idx_d    = idx;
      wren_d   = 1'b0;
      addr_d   = req_addr;
      colour_d = fade_scale(req_colour, req_level);

      if (fade_start) begin
         state_d = SWEEP;
         level_d = fade_level;
         idx_d   = '0;
      end else if (sweep_go) begin
         if (idx == PAL_AW'(PAL_ENTRIES - 1)) state_d = IDLE;
         else                                 idx_d   = idx + 1'b1;
      end

      // A blocked sweep holds idx and rewrites the entry later from the updated shadow.
      if (req_take) begin
         wren_d = 1'b1;
      end else if (sweep_go) begin
         wren_d   = 1'b1;
         addr_d   = idx;
         colour_d = fade_scale(shadow_rd, level);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         level <= '0;
         idx   <= '0;
      end else begin
         state <= state_d;
         level <= level_d;
         idx   <= idx_d;
      end
   end
`else
   logic unused_fade;

   assign unused_fade = ^{fade_level, fade_start};
   assign fade_busy   = 1'b0;

   always_comb begin
      wren_d   = req_take;
      addr_d   = req_addr;
      colour_d = req_colour;
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         pal_wren   <= 1'b0;
         pal_addr   <= '0;
         pal_wrdata <= '0;
      end else begin
         pal_wren   <= wren_d;
         pal_addr   <= addr_d;
         pal_wrdata <= {2'b00, colour_d};
      end
   end

endmodule

// File: tb/tb_palette_ctrl.sv
// Scoreboard bench for palette_ctrl: stimulus pushes expected palette writes, a monitor pops them.
// Fade scenarios are exercised when built with PALETTE_FADE_EN.
module tb_palette_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] cpu_addr, host_addr, pal_addr;
   logic [7:0] cpu_wrdata, host_wrdata, pal_wrdata;
   logic       cpu_wren, host_valid, host_ready;
   logic [1:0] fade_level;
   logic       fade_start, fade_busy, pal_wren;

   typedef struct {
      logic [4:0] a;
      logic [7:0] d;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   busy_cnt = 0;
   int   busy_rise = 0;
   int   b0, r0;

   palette_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_addr    (cpu_addr),
      .cpu_wrdata  (cpu_wrdata),
      .cpu_wren    (cpu_wren),
      .host_addr   (host_addr),
      .host_wrdata (host_wrdata),
      .host_valid  (host_valid),
      .host_ready  (host_ready),
      .fade_level  (fade_level),
      .fade_start  (fade_start),
      .fade_busy   (fade_busy),
      .pal_addr    (pal_addr),
      .pal_wrdata  (pal_wrdata),
      .pal_wren    (pal_wren)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [4:0] a, input logic [7:0] d);
      exp_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && fade_busy; i++) tick();
      check("sweep_done", fade_busy, 1'b0);
   endtask

   // Monitor: every palette write must match the oldest expected write.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (pal_wren) begin
            if (exp_q.size() == 0) begin
               check("unexpected_wren", pal_wren, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("pal_addr", pal_addr, e.a);
               check("pal_wrdata", pal_wrdata, e.d);
            end
         end
      end
   end

   // fade_busy high-cycle and rising-edge counters.
   initial begin
      logic prev = 1'b0;
      forever begin
         @(negedge clk);
         if (fade_busy && !prev) busy_rise++;
         if (fade_busy) busy_cnt++;
         prev = fade_busy;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      cpu_addr = '0; cpu_wrdata = '0; cpu_wren = 1'b0;
      host_addr = '0; host_wrdata = '0; host_valid = 1'b0;
      fade_level = '0; fade_start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_wren", pal_wren, 1'b0);
      check("reset_addr", pal_addr, 5'd0);
      check("reset_data", pal_wrdata, 8'h00);
      check("reset_busy", fade_busy, 1'b0);
      check("reset_host_ready", host_ready, 1'b1);
      tick();
      reset = 1'b0;

      // Single CPU write; host_ready drops during the strobe.
      tick();
      cpu_addr = 5'd5; cpu_wrdata = 8'h3F; cpu_wren = 1'b1; push(5'd5, 8'h3F);
      @(negedge clk);
      check("host_ready_strobe", host_ready, 1'b0);
      tick();
      cpu_wren = 1'b0;
      @(negedge clk);
      check("host_ready_idle", host_ready, 1'b1);

      // CPU and host together: CPU first, host the next cycle.
      tick();
      cpu_addr = 5'd1; cpu_wrdata = 8'h12; cpu_wren = 1'b1;
      host_addr = 5'd2; host_wrdata = 8'h2D; host_valid = 1'b1;
      push(5'd1, 8'h12);
      tick();
      cpu_wren = 1'b0; push(5'd2, 8'h2D);
      tick();
      host_valid = 1'b0;

      // Host held off by three back-to-back CPU writes.
      host_addr = 5'd12; host_wrdata = 8'hF0; host_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cpu_addr = 5'(8 + i); cpu_wrdata = 8'(i + 1); cpu_wren = 1'b1;
         push(5'(8 + i), 8'(i + 1));
         @(negedge clk);
         check("host_stalled", host_ready, 1'b0);
         tick();
      end
      cpu_wren = 1'b0; push(5'd12, 8'h30);
      tick();

      // Host writes 0xFF to the last entry: bits [7:6] are dropped.
      host_addr = 5'd31; host_wrdata = 8'hFF; host_valid = 1'b1; push(5'd31, 8'h3F);
      tick();
      host_valid = 1'b0;
      tick();

`ifdef PALETTE_FADE_EN
      // Fill the shadow with white.
      for (int i = 0; i < 32; i++) begin
         cpu_addr = 5'(i); cpu_wrdata = 8'hFF; cpu_wren = 1'b1; push(5'(i), 8'h3F);
         tick();
      end
      cpu_wren = 1'b0;
      tick();

      // Uncontested level-2 sweep.
      b0 = busy_cnt; r0 = busy_rise;
      fade_level = 2'd2; fade_start = 1'b1;
      for (int i = 0; i < 32; i++) push(5'(i), 8'h15);
      tick();
      fade_start = 1'b0;
      wait_idle();
      tick();
      check("busy_len_l2", busy_cnt - b0, 32);
      check("busy_rise_l2", busy_rise - r0, 1);

      // Level-1 sweep with a CPU write colliding at idx 10.
      b0 = busy_cnt;
      fade_level = 2'd1; fade_start = 1'b1;
      for (int i = 0; i < 10; i++) push(5'(i), 8'h2A);
      push(5'd10, 8'h15);
      push(5'd10, 8'h15);
      for (int i = 11; i < 32; i++) push(5'(i), 8'h2A);
      tick();
      fade_start = 1'b0;
      repeat (10) tick();
      cpu_addr = 5'd10; cpu_wrdata = 8'h2A; cpu_wren = 1'b1;
      tick();
      cpu_wren = 1'b0;
      wait_idle();
      tick();
      check("busy_len_collide", busy_cnt - b0, 33);

      // Level-1 sweep restarted at idx 20 with level 3.
      b0 = busy_cnt; r0 = busy_rise;
      fade_level = 2'd1; fade_start = 1'b1;
      for (int i = 0; i < 20; i++) push(5'(i), (i == 10) ? 8'h15 : 8'h2A);
      for (int i = 0; i < 32; i++) push(5'(i), 8'h00);
      tick();
      fade_start = 1'b0;
      repeat (20) tick();
      fade_level = 2'd3; fade_start = 1'b1;
      tick();
      fade_start = 1'b0;
      wait_idle();
      tick();
      check("busy_len_restart", busy_cnt - b0, 53);
      check("busy_rise_restart", busy_rise - r0, 1);

      // fade_start with a CPU write: the CPU entry uses the new level.
      b0 = busy_cnt;
      fade_level = 2'd1; fade_start = 1'b1;
      cpu_addr = 5'd7; cpu_wrdata = 8'h3F; cpu_wren = 1'b1;
      push(5'd7, 8'h2A);
      for (int i = 0; i < 32; i++) push(5'(i), (i == 10) ? 8'h15 : 8'h2A);
      tick();
      fade_start = 1'b0; cpu_wren = 1'b0;
      wait_idle();
      tick();
      check("busy_len_start_cpu", busy_cnt - b0, 32);

      // Reset mid-sweep clears shadow, level and state.
      fade_level = 2'd2; fade_start = 1'b1;
      for (int i = 0; i < 5; i++) push(5'(i), 8'h15);
      tick();
      fade_start = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      tick();
      tick();
      @(negedge clk);
      check("midreset_busy", fade_busy, 1'b0);
      check("midreset_wren", pal_wren, 1'b0);
      check("midreset_addr", pal_addr, 5'd0);
      tick();
      reset = 1'b0;
      tick();
      b0 = busy_cnt;
      fade_level = 2'd0; fade_start = 1'b1;
      for (int i = 0; i < 32; i++) push(5'(i), 8'h00);
      tick();
      fade_start = 1'b0;
      wait_idle();
      tick();
      check("busy_len_after_reset", busy_cnt - b0, 32);
`else
      // fade_start is ignored: no writes, fade_busy stays low, data stays unscaled.
      b0 = busy_cnt;
      fade_level = 2'd2; fade_start = 1'b1;
      tick();
      fade_start = 1'b0;
      repeat (40) tick();
      check("busy_never", busy_cnt - b0, 0);
      cpu_addr = 5'd3; cpu_wrdata = 8'h3F; cpu_wren = 1'b1; push(5'd3, 8'h3F);
      tick();
      cpu_wren = 1'b0;
      host_addr = 5'd31; host_wrdata = 8'hFF; host_valid = 1'b1; push(5'd31, 8'h3F);
      tick();
      host_valid = 1'b0;
      tick();
`endif

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
      tick();
      check("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
